c1_weight_loader: RTL

//  Sequences the conv-layer-1 weight ROMs. On request, reads one kernel's
//  CNN_KERNEL_SIZE parameters (addr 0..KERNEL_SIZE-1) from the selected ROM.

---
 rtl/c1_weight_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/c1_weight_loader.sv
// Conv-layer-1 weight loader: walks one kernel's addresses through the
// selected C1 weight ROM and packs the returned weights into a flat register.
module c1_weight_loader #(
  parameter int PARA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 25,
  parameter int KERNEL_NUM  = 6,
  parameter int ADDR_WIDTH  = 5,
  localparam int SEL_W      = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_req,
  input  logic [SEL_W-1:0]                  load_kid,
  input  logic                              abort,
  output logic [ADDR_WIDTH-1:0]             rom_raddr,
  output logic [SEL_W-1:0]                  rom_sel,
  input  logic [PARA_WIDTH-1:0]             rom_dout,
  output logic                              busy,
  output logic                              load_done,
  output logic                              load_err,
  output logic                              kernel_valid,
  output logic [PARA_WIDTH*KERNEL_SIZE-1:0] kernel_weights
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

  state_e                              state_q, state_d;
  logic [ADDR_WIDTH-1:0]               raddr_q, raddr_d;
  logic [SEL_W-1:0]                    sel_q, sel_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                err_q, err_d;
  logic                                kvalid_q, kvalid_d;
  logic                                cap_vld_q, cap_vld_d;
  logic [ADDR_WIDTH-1:0]               cap_idx_q, cap_idx_d;
  logic [PARA_WIDTH*KERNEL_SIZE-1:0]   kw_q, kw_d;

  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    kvalid_d  = kvalid_q;
    cap_vld_d = 1'b0;
    cap_idx_d = cap_idx_q;
    kw_d      = kw_q;

    // ROM data lags the address by one cycle, so the capture slot is the
    // address issued on the previous cycle.
    if (cap_vld_q) begin
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        if (cap_idx_q == ADDR_WIDTH'(k)) kw_d[k*PARA_WIDTH +: PARA_WIDTH] = rom_dout;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (load_req) begin
          if (int'(load_kid) < KERNEL_NUM) begin
            sel_d    = load_kid;
            raddr_d  = '0;
            busy_d   = 1'b1;
            kvalid_d = 1'b0;
            state_d  = S_READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cap_vld_d = 1'b1;
          cap_idx_d = raddr_q;
          if (raddr_q < LAST_ADDR) raddr_d = raddr_q + ADDR_WIDTH'(1);
          else                     state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!abort) begin
          done_d   = 1'b1;
          kvalid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      raddr_q   <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      kvalid_q  <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      kw_q      <= '0;
    end else begin
      state_q   <= state_d;
      raddr_q   <= raddr_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      kvalid_q  <= kvalid_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      kw_q      <= kw_d;
    end
  end

  assign rom_raddr      = raddr_q;
  assign rom_sel        = sel_q;
  assign busy           = busy_q;
  assign load_done      = done_q;
  assign load_err       = err_q;
  assign kernel_valid   = kvalid_q;
  assign kernel_weights = kw_q;

endmodule
